// File: rtl/ntr_cmd_capture.sv
// ntr_cmd_capture: oversamples the asynchronous NTR cartridge bus (ntr_clk,
// ntr_cs1, ntr_data) in the clk domain. It assembles the first CMD_BYTES bytes
// of each CS1-low frame into a command word, then streams the following bytes
// downstream with a saturating per-frame byte count.
module ntr_cmd_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CMD_BYTES   = 8,
    parameter int DCNT_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ntr_clk,
    input  logic                   ntr_cs1,
    input  logic [7:0]             ntr_data,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   cmd_valid,
    output logic                   frame_abort,
    output logic                   data_strobe,
    output logic [7:0]             data_byte,
    output logic [DCNT_W-1:0]      data_count,
    output logic                   data_ovf,
    output logic                   busy
);
    localparam int CMD_W   = 8 * CMD_BYTES;
    localparam int SHIFT_W = (CMD_BYTES > 1) ? 8 * (CMD_BYTES - 1) : 8;
    localparam int IDX_W   = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    // Synchroniser chain. Data travels with the control pins so the byte at
    // the chain output lines up with the detected ntr_clk rise.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic       clk_in;
            logic       cs_in;
            logic [7:0] data_in;
            logic       clk_reg;
            logic       cs_reg;
            logic [7:0] data_reg;
            if (gi == 0) begin : g_first
                assign clk_in  = ntr_clk;
                assign cs_in   = ntr_cs1;
                assign data_in = ntr_data;
            end else begin : g_next
                assign clk_in  = g_sync[gi-1].clk_reg;
                assign cs_in   = g_sync[gi-1].cs_reg;
                assign data_in = g_sync[gi-1].data_reg;
            end
            // One stage; control stages preset high so reset release shows no edge
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    clk_reg  <= 1'b1;
                    cs_reg   <= 1'b1;
                    data_reg <= '0;
                end else begin
                    clk_reg  <= clk_in;
                    cs_reg   <= cs_in;
                    data_reg <= data_in;
                end
            end
        end
    endgenerate

    logic       clk_s;
    logic       cs_s;
    logic [7:0] data_s;
    assign clk_s  = g_sync[SYNC_STAGES-1].clk_reg;
    assign cs_s   = g_sync[SYNC_STAGES-1].cs_reg;
    assign data_s = g_sync[SYNC_STAGES-1].data_reg;

    logic clk_prev_reg;
    logic cs_prev_reg;
    logic clk_rise;
    logic cs_rise;
    logic cs_fall;
    assign clk_rise = clk_s & ~clk_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    byte_idx_reg, byte_idx_next;
    logic [SHIFT_W-1:0]  shift_reg, shift_next;
    logic [CMD_W-1:0]    cmd_reg, cmd_next;
    logic                cmd_valid_reg, cmd_valid_next;
    logic                frame_abort_reg, frame_abort_next;
    logic                data_strobe_reg, data_strobe_next;
    logic [7:0]          data_byte_reg, data_byte_next;
    logic [DCNT_W-1:0]   data_count_reg, data_count_next;
    logic                data_ovf_reg, data_ovf_next;

    // shift_reg keeps only the earlier bytes; the final byte completes cmd_full
    logic [SHIFT_W-1:0] shift_in;
    logic [CMD_W-1:0]   cmd_full;
    generate
        if (CMD_BYTES > 2) begin : g_shift_wide
            assign shift_in = {shift_reg[SHIFT_W-9:0], data_s};
            assign cmd_full = {shift_reg, data_s};
        end else if (CMD_BYTES == 2) begin : g_shift_one
            assign shift_in = data_s;
            assign cmd_full = {shift_reg, data_s};
        end else begin : g_shift_none
            assign shift_in = data_s;
            assign cmd_full = data_s;
        end
    endgenerate

    // Frame FSM and output next-state; a CS1 rise overrides everything else
    always_comb begin
        state_next       = state_reg;
        byte_idx_next    = byte_idx_reg;
        shift_next       = shift_reg;
        cmd_next         = cmd_reg;
        cmd_valid_next   = 1'b0;
        frame_abort_next = 1'b0;
        data_strobe_next = 1'b0;
        data_byte_next   = data_byte_reg;
        data_count_next  = data_count_reg;
        data_ovf_next    = data_ovf_reg;
        if (cs_rise) begin
            state_next       = ST_IDLE;
            frame_abort_next = (state_reg == ST_CMD) && (byte_idx_reg != '0);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // a clock rise coinciding with the CS1 fall is not a byte
                    if (cs_fall) begin
                        state_next      = ST_CMD;
                        byte_idx_next   = '0;
                        data_count_next = '0;
                        data_ovf_next   = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (clk_rise) begin
                        if (byte_idx_reg == LAST_IDX) begin
                            cmd_next       = cmd_full;
                            cmd_valid_next = 1'b1;
                            byte_idx_next  = '0;
                            state_next     = ST_DATA;
                        end else begin
                            shift_next    = shift_in;
                            byte_idx_next = byte_idx_reg + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (clk_rise) begin
                        data_strobe_next = 1'b1;
                        data_byte_next   = data_s;
                        if (data_count_reg == '1) begin
                            data_ovf_next = 1'b1;
                        end else begin
                            data_count_next = data_count_reg + 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, edge-history and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_prev_reg    <= 1'b1;
            cs_prev_reg     <= 1'b1;
            state_reg       <= ST_IDLE;
            byte_idx_reg    <= '0;
            shift_reg       <= '0;
            cmd_reg         <= '0;
            cmd_valid_reg   <= 1'b0;
            frame_abort_reg <= 1'b0;
            data_strobe_reg <= 1'b0;
            data_byte_reg   <= '0;
            data_count_reg  <= '0;
            data_ovf_reg    <= 1'b0;
        end else begin
            clk_prev_reg    <= clk_s;
            cs_prev_reg     <= cs_s;
            state_reg       <= state_next;
            byte_idx_reg    <= byte_idx_next;
            shift_reg       <= shift_next;
            cmd_reg         <= cmd_next;
            cmd_valid_reg   <= cmd_valid_next;
            frame_abort_reg <= frame_abort_next;
            data_strobe_reg <= data_strobe_next;
            data_byte_reg   <= data_byte_next;
            data_count_reg  <= data_count_next;
            data_ovf_reg    <= data_ovf_next;
        end
    end

    assign cmd         = cmd_reg;
    assign cmd_valid   = cmd_valid_reg;
    assign frame_abort = frame_abort_reg;
    assign data_strobe = data_strobe_reg;
    assign data_byte   = data_byte_reg;
    assign data_count  = data_count_reg;
    assign data_ovf    = data_ovf_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ntr_cmd_capture.sv
// tb_ntr_cmd_capture: drives NTR bus frames into two instances (12-bit and
// 2-bit data counters). A frame model pushes expected commands, data bytes
// and aborts into queues; a negedge monitor pops and compares them.
module tb_ntr_cmd_capture;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ntr_clk = 1'b1;
    logic       ntr_cs1 = 1'b1;
    logic [7:0] ntr_data = 8'h00;

    logic [63:0] m_cmd, s_cmd;
    logic        m_cmd_valid, s_cmd_valid;
    logic        m_frame_abort, s_frame_abort;
    logic        m_data_strobe, s_data_strobe;
    logic [7:0]  m_data_byte, s_data_byte;
    logic [11:0] m_data_count;
    logic [1:0]  s_data_count;
    logic        m_data_ovf, s_data_ovf;
    logic        m_busy, s_busy;

    ntr_cmd_capture #(.SYNC_STAGES(SS), .CMD_BYTES(8), .DCNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
        .ntr_data(ntr_data), .cmd(m_cmd), .cmd_valid(m_cmd_valid),
        .frame_abort(m_frame_abort), .data_strobe(m_data_strobe),
        .data_byte(m_data_byte), .data_count(m_data_count),
        .data_ovf(m_data_ovf), .busy(m_busy)
    );

    ntr_cmd_capture #(.SYNC_STAGES(SS), .CMD_BYTES(8), .DCNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
        .ntr_data(ntr_data), .cmd(s_cmd), .cmd_valid(s_cmd_valid),
        .frame_abort(s_frame_abort), .data_strobe(s_data_strobe),
        .data_byte(s_data_byte), .data_count(s_data_count),
        .data_ovf(s_data_ovf), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0]  b;
        logic [11:0] cnt;
        logic        ovf;
    } dexp_t;

    logic [63:0] cmdq_m[$];
    logic [63:0] cmdq_s[$];
    dexp_t       dq_m[$];
    dexp_t       dq_s[$];
    int          abort_m = 0;
    int          abort_s = 0;
    int          last_rise_cyc = 0;
    int          last_cs_cyc = 0;

    // frame model: 0 idle, 1 command, 2 data
    int          md_state = 0;
    int          md_idx = 0;
    logic [63:0] md_shift = '0;
    int          cnt_m = 0;
    int          cnt_s = 0;
    logic        ovf_m = 1'b0;
    logic        ovf_s = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        dexp_t d;
        if (md_state == 1) begin
            md_shift = {md_shift[55:0], b};
            md_idx++;
            if (md_idx == 8) begin
                cmdq_m.push_back(md_shift);
                cmdq_s.push_back(md_shift);
                md_state = 2;
                md_idx = 0;
            end
        end else if (md_state == 2) begin
            if (cnt_m == 4095) ovf_m = 1'b1; else cnt_m++;
            if (cnt_s == 3) ovf_s = 1'b1; else cnt_s++;
            d.b = b; d.cnt = 12'(cnt_m); d.ovf = ovf_m;
            dq_m.push_back(d);
            d.cnt = 12'(cnt_s); d.ovf = ovf_s;
            dq_s.push_back(d);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ntr_data = b;
        ntr_clk  = 1'b0;
        repeat (5) @(negedge clk);
        ntr_clk = 1'b1;
        last_rise_cyc = cyc;
        model_byte(b);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [63:0] c);
        logic [63:0] w;
        w = c;
        for (int i = 7; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        ntr_cs1 = 1'b0;
        md_state = 1; md_idx = 0;
        cnt_m = 0; cnt_s = 0; ovf_m = 1'b0; ovf_s = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        ntr_cs1 = 1'b1;
        last_cs_cyc = cyc;
        if (md_state == 1 && md_idx > 0) begin
            abort_m++;
            abort_s++;
        end
        md_state = 0;
        repeat (6) @(negedge clk);
        check_eq("abort_drained", 64'(abort_m + abort_s), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ntr_cs1 = 1'b1;
        md_state = 0;
        repeat (4) begin
            @(negedge clk);
            ntr_clk = ~ntr_clk;
        end
        check_eq("rst_cmd_m", m_cmd, 64'd0);
        check_eq("rst_cmd_s", s_cmd, 64'd0);
        check_eq("rst_flags_m", 64'({m_cmd_valid, m_frame_abort, m_data_strobe, m_data_byte,
                                     m_data_count, m_data_ovf, m_busy}), 64'd0);
        check_eq("rst_flags_s", 64'({s_cmd_valid, s_frame_abort, s_data_strobe, s_data_byte,
                                     s_data_count, s_data_ovf, s_busy}), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        check_eq(tag, 64'(cmdq_m.size() + cmdq_s.size() + dq_m.size() + dq_s.size()), 64'd0);
    endtask

    // scoreboard monitor, main instance
    always @(negedge clk) begin : mon_m
        logic [63:0] ce;
        dexp_t d;
        if (rst_n) begin
            if (m_cmd_valid) begin
                if (cmdq_m.size() == 0) check_eq("m_cmd_valid_extra", 64'd1, 64'd0);
                else begin
                    ce = cmdq_m.pop_front();
                    check_eq("m_cmd", m_cmd, ce);
                    check_eq("m_cmd_lat", 64'(cyc - last_rise_cyc), 64'(LAT));
                end
            end
            if (m_data_strobe) begin
                if (dq_m.size() == 0) check_eq("m_strobe_extra", 64'd1, 64'd0);
                else begin
                    d = dq_m.pop_front();
                    check_eq("m_data_byte", 64'(m_data_byte), 64'(d.b));
                    check_eq("m_data_count", 64'(m_data_count), 64'(d.cnt));
                    check_eq("m_data_ovf", 64'(m_data_ovf), 64'(d.ovf));
                    check_eq("m_data_lat", 64'(cyc - last_rise_cyc), 64'(LAT));
                end
            end
            if (m_frame_abort) begin
                if (abort_m == 0) check_eq("m_abort_extra", 64'd1, 64'd0);
                else begin
                    abort_m--;
                    check_eq("m_abort_lat", 64'(cyc - last_cs_cyc), 64'(LAT));
                end
            end
        end
    end

    // scoreboard monitor, saturating instance
    always @(negedge clk) begin : mon_s
        logic [63:0] ce;
        dexp_t d;
        if (rst_n) begin
            if (s_cmd_valid) begin
                if (cmdq_s.size() == 0) check_eq("s_cmd_valid_extra", 64'd1, 64'd0);
                else begin
                    ce = cmdq_s.pop_front();
                    check_eq("s_cmd", s_cmd, ce);
                end
            end
            if (s_data_strobe) begin
                if (dq_s.size() == 0) check_eq("s_strobe_extra", 64'd1, 64'd0);
                else begin
                    d = dq_s.pop_front();
                    check_eq("s_data_byte", 64'(s_data_byte), 64'(d.b));
                    check_eq("s_data_count", 64'(s_data_count), 64'(d.cnt));
                    check_eq("s_data_ovf", 64'(s_data_ovf), 64'(d.ovf));
                end
            end
            if (s_frame_abort) begin
                if (abort_s == 0) check_eq("s_abort_extra", 64'd1, 64'd0);
                else abort_s--;
            end
        end
    end

    initial begin
        // reset with ntr_clk toggling, then a quiet window
        do_reset();

        // single command
        cs_low();
        send_cmd(64'h9F00_0000_0000_0001);
        check_eq("busy_after_cmd", 64'(m_busy), 64'd1);
        cs_high();
        drain_check("drain_cmd");

        // abort after three bytes, then a clean command
        cs_low();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        cs_high();
        check_eq("busy_after_abort", 64'(m_busy), 64'd0);
        check_eq("cmd_hold_abort", m_cmd, 64'h9F00_0000_0000_0001);
        cs_low();
        send_cmd(64'hA55A_C33C_0102_0304);
        cs_high();
        drain_check("drain_abort");

        // data phase
        cs_low();
        send_cmd(64'hB700_0000_0000_0000);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        cs_high();
        check_eq("data_byte_hold", 64'(m_data_byte), 64'h44);
        drain_check("drain_data");

        // saturation on the 2-bit counter
        cs_low();
        send_cmd(64'h0102_0304_0506_0708);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        check_eq("sat_count", 64'(s_data_count), 64'd3);
        check_eq("sat_ovf", 64'(s_data_ovf), 64'd1);
        cs_high();
        cs_low();
        check_eq("sat_count_clr", 64'(s_data_count), 64'd0);
        check_eq("sat_ovf_clr", 64'(s_data_ovf), 64'd0);
        check_eq("m_count_clr", 64'(m_data_count), 64'd0);
        cs_high();
        drain_check("drain_sat");

        // reset mid-command, then a fresh frame
        cs_low();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        do_reset();
        cs_low();
        send_cmd(64'h9000_0000_0000_0000);
        check_eq("cmd_after_reset", m_cmd, 64'h9000_0000_0000_0000);
        cs_high();
        drain_check("drain_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
